freq_gen: RTL and testbench



---
 rtl/freq_gen_pkg.sv | 26 ++
 rtl/freq_gen_cfg.sv | 65 ++++++
 rtl/freq_gen.sv | 116 +++++++++++
 tb/tb_freq_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg: shared types, reset defaults and config legality rule for freq_gen.
// Contents: state_t (IDLE/HIGH/LOW), cfg_t {div, high}, DEF_DIV_C/DEF_HIGH_C, cfg_legal().
// cfg_t is sized by CFG_W; freq_gen's DIV_W must not exceed it.
package freq_gen_pkg;

  localparam int unsigned CFG_W      = 32;
  localparam int unsigned DEF_DIV_C  = 10;
  localparam int unsigned DEF_HIGH_C = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } cfg_t;

  // A period needs at least one high and one low cycle.
  function automatic logic cfg_legal(input cfg_t c);
    return (c.div >= CFG_W'(2)) && (c.high >= CFG_W'(1)) && (c.high < c.div);
  endfunction

endpackage

// File: rtl/freq_gen_cfg.sv
// freq_gen_cfg: config handshake, validation and single-entry pending register.
// Ports: cfg_valid_i/cfg_ready_o/cfg_div_i/cfg_high_i handshake in, cfg_err_o pulse out,
//        pend_vld_o/pend_o to the FSM, pend_clr_i from the FSM when it consumes a period start.
module freq_gen_cfg
  import freq_gen_pkg::*;
#(
  parameter int unsigned DIV_W = CFG_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [DIV_W-1:0] cfg_high_i,
  output logic             cfg_err_o,
  output logic             pend_vld_o,
  output cfg_t             pend_o,
  input  logic             pend_clr_i
);

  logic pend_vld_q, pend_vld_d;
  cfg_t pend_q, pend_d;
  logic err_q, err_d;
  cfg_t cand;
  logic xfer;

  assign cand.div    = CFG_W'(cfg_div_i);
  assign cand.high   = CFG_W'(cfg_high_i);
  assign cfg_ready_o = ~pend_vld_q;
  assign xfer        = cfg_valid_i & cfg_ready_o;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    if (pend_clr_i) pend_vld_d = 1'b0;
    // A transfer can only happen with the slot empty, so it never races a
    // clear of live data; when both land together the new config must survive.
    if (xfer) begin
      if (cfg_legal(cand)) begin
        pend_vld_d = 1'b1;
        pend_d     = cand;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign cfg_err_o  = err_q;
  assign pend_vld_o = pend_vld_q;
  assign pend_o     = pend_q;

endmodule

// File: rtl/freq_gen.sv
// freq_gen: programmable glitch-free square wave; period/high time in sys_clk cycles.
// Ports: sys_clk/sys_rst, en run enable, cfg_* valid/ready config, clk_out (registered),
//        period_done (last cycle of each period), cfg_err (illegal config pulse), period_cnt.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int unsigned DIV_W    = CFG_W,
  parameter int unsigned DEF_DIV  = DEF_DIV_C,
  parameter int unsigned DEF_HIGH = DEF_HIGH_C
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             period_done,
  output logic             cfg_err,
  output logic [31:0]      period_cnt
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] high_q, high_d;
  logic [31:0]      pcnt_q;
  logic             clk_q;
  logic             boundary;
  logic             load;
  logic             pend_vld;
  cfg_t             pend;

  freq_gen_cfg #(.DIV_W(DIV_W)) u_cfg (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_div_i   (cfg_div),
    .cfg_high_i  (cfg_high),
    .cfg_err_o   (cfg_err),
    .pend_vld_o  (pend_vld),
    .pend_o      (pend),
    .pend_clr_i  (load)
  );

  // Last cycle of a period: the only point where settings may change.
  assign boundary = (state_q == LOW) && (cnt_q == div_q - ONE);

  // State register (plus counters and active settings).
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DEF_DIV);
      high_q  <= DIV_W'(DEF_HIGH);
      pcnt_q  <= '0;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      pcnt_q  <= pcnt_q + 32'(boundary);
      clk_q   <= (state_d == HIGH);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    high_d  = high_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = HIGH;
      end
      HIGH: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == high_q - ONE) state_d = LOW;
      end
      LOW: begin
        if (boundary) begin
          cnt_d   = '0;
          state_d = en ? HIGH : IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // A new period starts: adopt the pending config if one was registered.
    if (load && pend_vld) begin
      div_d  = pend.div[DIV_W-1:0];
      high_d = pend.high[DIV_W-1:0];
    end
  end

  // Outputs.
  always_comb begin
    load        = en && ((state_q == IDLE) || boundary);
    period_done = boundary;
  end

  assign clk_out    = clk_q;
  assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed self-checking bench for freq_gen.
// Drives inputs and samples outputs on the falling edge of sys_clk.
// Expected values are hand-computed constants.
module tb_freq_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic [31:0] cfg_high;
  logic        clk_out;
  logic        period_done;
  logic        cfg_err;
  logic [31:0] period_cnt;

  int checks = 0;
  int errors = 0;

  freq_gen dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .clk_out     (clk_out),
    .period_done (period_done),
    .cfg_err     (cfg_err),
    .period_cnt  (period_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait until clk_out shows a 0 -> 1 transition (first high sample).
  task automatic sync_rise(output bit found);
    int guard = 0;
    while (clk_out !== 1'b0 && guard < 1000) begin @(negedge sys_clk); guard++; end
    while (clk_out !== 1'b1 && guard < 1000) begin @(negedge sys_clk); guard++; end
    found = (clk_out === 1'b1);
  endtask

  // Called on the first high sample of a period; returns at the first high
  // sample of the following period.
  task automatic measure(output int hi, output int lo);
    int guard = 0;
    hi = 0;
    lo = 0;
    while (clk_out === 1'b1 && guard < 1000) begin hi++; guard++; @(negedge sys_clk); end
    while (clk_out === 1'b0 && guard < 1000) begin lo++; guard++; @(negedge sys_clk); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, pd, pd_at, n;
    bit found;
    logic [31:0] bad_div [3];
    logic [31:0] bad_high[3];
    bad_div[0] = 32'd1; bad_high[0] = 32'd0;
    bad_div[1] = 32'd8; bad_high[1] = 32'd0;
    bad_div[2] = 32'd8; bad_high[2] = 32'd8;

    sys_rst   = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_high  = '0;

    // Reset state.
    repeat (3) @(negedge sys_clk);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_period_done", 32'(period_done), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);

    // Default 10-cycle period, 5 high.
    sys_rst = 1'b0;
    en      = 1'b1;
    hi = 0; pd = 0; pd_at = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge sys_clk);
      if (i == 1) check("first_edge_latency", 32'(clk_out), 1);
      hi += int'(clk_out);
      if (period_done === 1'b1) begin
        pd++;
        if (pd_at == 0) pd_at = i;
      end
    end
    check("def_high_cycles", hi, 50);
    check("def_period_done_count", pd, 10);
    check("def_first_done_at", pd_at, 10);
    @(negedge sys_clk);
    check("def_period_cnt", period_cnt, 10);

    // Config 250/100 offered at cnt=3 of a default period.
    repeat (3) @(negedge sys_clk);
    cfg_valid = 1'b1; cfg_div = 32'd250; cfg_high = 32'd100;
    @(negedge sys_clk);
    check("cfg_ready_after_accept", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("cur_period_done", 32'(period_done), 1);
    check("cur_period_clk_low", 32'(clk_out), 0);
    check("ready_held_at_boundary", 32'(cfg_ready), 0);
    @(negedge sys_clk);
    check("new_period_clk_high", 32'(clk_out), 1);
    check("ready_back", 32'(cfg_ready), 1);
    check("period_cnt_11", period_cnt, 11);
    measure(hi, lo);
    check("p250_high", hi, 100);
    check("p250_low", lo, 150);

    // Illegal configs: error pulse, no change.
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1'b1; cfg_div = bad_div[k]; cfg_high = bad_high[k];
      @(negedge sys_clk);
      check($sformatf("bad%0d_err", k), 32'(cfg_err), 1);
      check($sformatf("bad%0d_ready", k), 32'(cfg_ready), 1);
      cfg_valid = 1'b0;
      @(negedge sys_clk);
      check($sformatf("bad%0d_err_clear", k), 32'(cfg_err), 0);
    end
    sync_rise(found);
    check("bad_sync", 32'(found), 1);
    measure(hi, lo);
    check("bad_keep_high", hi, 100);
    check("bad_keep_low", lo, 150);

    // A = 2/1 accepted, then B = 6/2 held off until A is consumed.
    cfg_valid = 1'b1; cfg_div = 32'd2; cfg_high = 32'd1;
    @(negedge sys_clk);
    check("a_ready_low", 32'(cfg_ready), 0);
    cfg_div = 32'd6; cfg_high = 32'd2;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 1000) begin @(negedge sys_clk); n++; end
    check("b_wait_cycles", n, 249);
    check("a_period_high", 32'(clk_out), 1);
    @(negedge sys_clk);
    check("a_period_done", 32'(period_done), 1);
    check("a_period_low", 32'(clk_out), 0);
    check("b_pending_ready", 32'(cfg_ready), 0);
    check("b_no_err", 32'(cfg_err), 0);
    cfg_valid = 1'b0;
    @(negedge sys_clk);
    check("b_start_high", 32'(clk_out), 1);
    measure(hi, lo);
    check("b_high", hi, 2);
    check("b_low", lo, 4);

    // Back to 10/5, then drop en at cnt=2.
    cfg_valid = 1'b1; cfg_div = 32'd10; cfg_high = 32'd5;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    sync_rise(found);
    check("p10_sync", 32'(found), 1);
    measure(hi, lo);
    check("p10_high", hi, 5);
    check("p10_low", lo, 5);
    repeat (2) @(negedge sys_clk);
    en = 1'b0;
    hi = 0; pd = 0; pd_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      hi += int'(clk_out);
      if (period_done === 1'b1) begin pd++; pd_at = k; end
    end
    check("stop_high_left", hi, 2);
    check("stop_done_count", pd, 1);
    check("stop_done_at", pd_at, 7);
    check("idle_clk_low", 32'(clk_out), 0);
    en = 1'b1;
    @(negedge sys_clk);
    check("restart_latency", 32'(clk_out), 1);
    measure(hi, lo);
    check("restart_high", hi, 5);
    check("restart_low", lo, 5);

    // Reset while clk_out is high with 250/100 pending.
    cfg_valid = 1'b1; cfg_div = 32'd250; cfg_high = 32'd100;
    @(negedge sys_clk);
    check("rst_pend_ready", 32'(cfg_ready), 0);
    check("rst_pre_clk_high", 32'(clk_out), 1);
    cfg_valid = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    check("rst_async_clk", 32'(clk_out), 0);
    check("rst_async_ready", 32'(cfg_ready), 1);
    check("rst_async_pcnt", period_cnt, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("post_rst_high", 32'(clk_out), 1);
    measure(hi, lo);
    check("post_rst_p_high", hi, 5);
    check("post_rst_p_low", lo, 5);
    check("post_rst_pcnt", period_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
